// File: rtl/adpll_pkg.sv
// adpll_pkg: lock-state encoding, slip counter width and saturating magnitude helper shared by ADPLL stages
package adpll_pkg;
  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2,
    SLIPPING  = 2'd3
  } lock_state_e;
  localparam int SLIP_W = 8;
  // x is a sign-extended w-bit value; the most-negative code maps to the largest positive one
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int w);
    logic [31:0] lim, m;
    lim = (32'd1 << (w - 1)) - 32'd1;
    m = x[31] ? 32'(-x) : 32'(x);
    return (m > lim) ? lim : m;
  endfunction
endpackage

// File: rtl/ref_edge_sync.sv
// ref_edge_sync: 2-FF synchronizer plus registered one-cycle pulse on each rising edge of an async input
module ref_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);
  logic [1:0] sync_q;
  logic prev_q, pulse_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], d_i};
      prev_q  <= sync_q[1];
      pulse_q <= sync_q[1] & ~prev_q;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/adpll_lock_detect.sv
// adpll_lock_detect: qualifies ADPLL lock from phase error and DCO code stability per reference edge,
// with hysteresis, loss-of-reference timeout and a saturating slip counter
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH  = 8,
  parameter int DCO_CC_WIDTH = 9,
  parameter int LOCK_TOL     = 2,
  parameter int CC_TOL       = 4,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int REF_TIMEOUT  = 1024
) (
  input  logic                                fpga_clk_i,
  input  logic                                reset_i,
  input  logic                                enable_i,
  input  logic                                ref_clk_i,
  input  logic signed [ERROR_WIDTH-1:0]       error_i,
  input  logic signed [DCO_CC_WIDTH-1:0]      dco_cc_i,
  input  logic                                clear_stats_i,
  output logic                                locked_o,
  output logic [1:0]                          state_o,
  output logic [$clog2(LOCK_COUNT+1)-1:0]     lock_count_o,
  output logic                                loss_of_ref_o,
  output logic [SLIP_W-1:0]                   slip_count_o
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);
  localparam int TW = $clog2(REF_TIMEOUT + 1);
  lock_state_e state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [TW-1:0] timer_q, timer_d;
  logic signed [DCO_CC_WIDTH-1:0] cc_prev_q, cc_prev_d;
  logic [SLIP_W-1:0] slip_q, slip_d;
  logic have_prev_q, have_prev_d, lor_q, lor_d, slip_inc, smp, inwin;
  logic signed [DCO_CC_WIDTH:0] delta;
  logic [31:0] err_mag, cc_mag;
  ref_edge_sync u_sync (
    .clk_i  (fpga_clk_i),
    .rst_i  (reset_i),
    .d_i    (ref_clk_i),
    .pulse_o(smp)
  );
  always_comb begin
    delta = {dco_cc_i[DCO_CC_WIDTH-1], dco_cc_i} - {cc_prev_q[DCO_CC_WIDTH-1], cc_prev_q};
    err_mag = sat_abs(32'(error_i), ERROR_WIDTH);
    cc_mag = have_prev_q ? sat_abs(32'(delta), DCO_CC_WIDTH + 1) : '0;
    inwin = (err_mag <= 32'(LOCK_TOL)) && (cc_mag <= 32'(CC_TOL));
    state_d = state_q;
    run_d = run_q;
    miss_d = miss_q;
    timer_d = timer_q;
    cc_prev_d = cc_prev_q;
    have_prev_d = have_prev_q;
    lor_d = lor_q;
    slip_inc = 1'b0;
    if (!enable_i) begin
      state_d = UNLOCKED;
      run_d = '0;
      miss_d = '0;
      timer_d = '0;
      lor_d = 1'b0;
      have_prev_d = 1'b0;
    end else if (smp) begin
      timer_d = '0;
      lor_d = 1'b0;
      have_prev_d = 1'b1;
      cc_prev_d = dco_cc_i;
      case (state_q)
        UNLOCKED: begin
          state_d = inwin ? ACQUIRING : UNLOCKED;
          run_d = inwin ? RW'(1) : '0;
        end
        ACQUIRING: begin
          state_d = !inwin ? UNLOCKED : (run_q + RW'(1) == RW'(LOCK_COUNT)) ? LOCKED : ACQUIRING;
          run_d = inwin ? run_q + RW'(1) : '0;
        end
        LOCKED: begin
          state_d = inwin ? LOCKED : SLIPPING;
          miss_d = inwin ? '0 : MW'(1);
        end
        SLIPPING: begin
          slip_inc = !inwin && (miss_q + MW'(1) == MW'(UNLOCK_COUNT));
          state_d = inwin ? LOCKED : slip_inc ? UNLOCKED : SLIPPING;
          miss_d = (inwin || slip_inc) ? '0 : miss_q + MW'(1);
          run_d = slip_inc ? '0 : run_q;
        end
      endcase
    end else if (timer_q == TW'(REF_TIMEOUT - 1)) begin
      // reference lost: timer parks at terminal count until the next strobe
      timer_d = TW'(REF_TIMEOUT);
      lor_d = 1'b1;
      state_d = UNLOCKED;
      run_d = '0;
      miss_d = '0;
      have_prev_d = 1'b0;
      slip_inc = state_q[1];
    end else if (timer_q != TW'(REF_TIMEOUT)) begin
      timer_d = timer_q + TW'(1);
    end
    slip_d = clear_stats_i ? '0 : (slip_inc && slip_q != '1) ? slip_q + SLIP_W'(1) : slip_q;
  end
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q <= UNLOCKED;
      run_q <= '0;
      miss_q <= '0;
      timer_q <= '0;
      cc_prev_q <= '0;
      have_prev_q <= 1'b0;
      lor_q <= 1'b0;
      slip_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      miss_q <= miss_d;
      timer_q <= timer_d;
      cc_prev_q <= cc_prev_d;
      have_prev_q <= have_prev_d;
      lor_q <= lor_d;
      slip_q <= slip_d;
    end
  end
  assign locked_o = state_q[1];
  assign state_o = state_q;
  assign lock_count_o = run_q;
  assign loss_of_ref_o = lor_q;
  assign slip_count_o = slip_q;
endmodule

// File: tb/tb_adpll_lock_detect.sv
// tb_adpll_lock_detect: directed plus randomized stimulus, per-cycle expected outputs queued by a
// behavioural model and popped by an independent monitor just after each clock edge
module tb_adpll_lock_detect;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, ref_clk = 1'b0, clr = 1'b0;
  logic signed [7:0] err = '0;
  logic signed [8:0] cc = '0;
  logic locked, lor;
  logic [1:0] state;
  logic [4:0] run;
  logic [7:0] slip;
  always #5 clk = ~clk;
  adpll_lock_detect dut (
    .fpga_clk_i   (clk),
    .reset_i      (rst),
    .enable_i     (en),
    .ref_clk_i    (ref_clk),
    .error_i      (err),
    .dco_cc_i     (cc),
    .clear_stats_i(clr),
    .locked_o     (locked),
    .state_o      (state),
    .lock_count_o (run),
    .loss_of_ref_o(lor),
    .slip_count_o (slip)
  );
  typedef struct packed {
    logic       locked;
    logic [1:0] st;
    logic [4:0] run;
    logic       lor;
    logic [7:0] slip;
  } out_t;
  out_t exp_q[$];
  out_t exp_o, act_o;
  int n_cmp = 0, n_bad = 0, cyc_n = 0;
  // model state: 0 unlocked, 1 acquiring, 2 locked, 3 slipping
  int m_st, m_run, m_miss, m_timer, m_slip, m_prev;
  bit m_lor, m_have;
  bit [3:0] m_ref;
  function automatic int mag(int x, int lim);
    int a;
    a = (x < 0) ? -x : x;
    return (a > lim) ? lim : a;
  endfunction
  task automatic model_step(bit rs, bit en_v, bit clr_v, bit r, int e, int c);
    bit smp, ok, inc;
    out_t o;
    if (rs) begin
      m_st = 0; m_run = 0; m_miss = 0; m_timer = 0; m_slip = 0; m_prev = 0;
      m_lor = 0; m_have = 0; m_ref = '0;
    end else begin
      smp = m_ref[2] && !m_ref[3];
      m_ref = {m_ref[2:0], r};
      inc = 0;
      if (!en_v) begin
        m_st = 0; m_run = 0; m_miss = 0; m_timer = 0; m_lor = 0; m_have = 0;
      end else if (smp) begin
        ok = (mag(e, 127) <= 2) && (!m_have || mag(c - m_prev, 511) <= 4);
        m_prev = c; m_have = 1; m_timer = 0; m_lor = 0;
        if (!ok) begin
          if (m_st == 2) begin
            m_st = 3; m_miss = 1;
          end else if (m_st == 3) begin
            m_miss++;
            if (m_miss == 4) begin m_st = 0; m_run = 0; m_miss = 0; inc = 1; end
          end else begin
            m_st = 0; m_run = 0;
          end
        end else begin
          m_miss = 0;
          if (m_st == 3) m_st = 2;
          else if (m_st < 2) begin m_run++; m_st = (m_run == 16) ? 2 : 1; end
        end
      end else if (m_timer < 1024) begin
        m_timer++;
        if (m_timer == 1024) begin
          inc = m_st >= 2;
          m_st = 0; m_run = 0; m_miss = 0; m_lor = 1; m_have = 0;
        end
      end
      if (clr_v) m_slip = 0;
      else if (inc && m_slip < 255) m_slip++;
    end
    o.locked = m_st >= 2;
    o.st = 2'(m_st);
    o.run = 5'(m_run);
    o.lor = m_lor;
    o.slip = 8'(m_slip);
    exp_q.push_back(o);
  endtask
  task automatic cyc(bit r, int e, int c, bit en_v = 1'b1, bit clr_v = 1'b0, bit rs = 1'b0);
    @(negedge clk);
    ref_clk = r; err = 8'(e); cc = 9'(c); en = en_v; clr = clr_v; rst = rs;
    model_step(rs, en_v, clr_v, r, e, c);
  endtask
  task automatic period(int n, int e, int c, bit en_v = 1'b1);
    for (int i = 0; i < n; i++) cyc(i < n / 2, e, c, en_v);
  endtask
  always @(posedge clk) begin
    #1;
    cyc_n++;
    if (exp_q.size() > 0) begin
      exp_o = exp_q.pop_front();
      act_o = {locked, state, run, lor, slip};
      n_cmp++;
      if (act_o !== exp_o) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got locked=%0b state=%0d run=%0d lor=%0b slip=%0d, expected locked=%0b state=%0d run=%0d lor=%0b slip=%0d",
                 cyc_n, act_o.locked, act_o.st, act_o.run, act_o.lor, act_o.slip,
                 exp_o.locked, exp_o.st, exp_o.run, exp_o.lor, exp_o.slip);
      end
    end
  end
  initial begin
    int c, n, e, len;
    bit noisy;
    repeat (3) cyc(0, 0, 0, 1'b1, 1'b0, 1'b1);
    repeat (17) period(400, 0, 37);
    repeat (4) period(20, 10, 37);
    cyc(0, 0, 37, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) period(20, (i % 2) ? -2 : 2, 37);
    repeat (4) period(20, 10, 37);
    repeat (5) period(20, 0, 37);
    period(20, 3, 37);
    period(20, -128, 37);
    repeat (17) period(20, 0, 37);
    period(20, 0, 42);
    period(20, 0, 42);
    repeat (1100) cyc(0, 0, 42);
    repeat (17) period(20, 0, 42);
    period(20, 10, 42);
    repeat (5) cyc(1, 0, 42);
    cyc(0, 0, 42, 1'b1, 1'b0, 1'b1);
    repeat (17) period(20, 0, 42);
    repeat (4) period(20, 10, 42);
    repeat (17) period(20, 0, 42);
    repeat (30) cyc(0, 0, 42, 1'b0);
    repeat (17) period(20, 0, 42);
    c = 42;
    for (int seg = 0; seg < 30; seg++) begin
      noisy = $urandom_range(0, 2) == 0;
      len = $urandom_range(10, 30);
      for (int p = 0; p < len; p++) begin
        n = $urandom_range(6, 30);
        e = ($urandom_range(0, noisy ? 1 : 30) == 0) ? int'($urandom_range(0, 255)) - 128
                                                      : int'($urandom_range(0, 4)) - 2;
        c += ($urandom_range(0, noisy ? 1 : 30) == 0) ? int'($urandom_range(0, 20)) - 10
                                                       : int'($urandom_range(0, 8)) - 4;
        if (c > 255) c = 255;
        if (c < -256) c = -256;
        period(n, e, c, $urandom_range(0, 40) != 0);
        if ($urandom_range(0, 25) == 0) cyc(0, 0, c, 1'b1, 1'b1);
        if ($urandom_range(0, 150) == 0) cyc(0, 0, c, 1'b1, 1'b0, 1'b1);
      end
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected outputs left uncompared, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
